dom_gf_mult_pipe: RTL and testbench

//  Pipelined first/higher-order DOM-independent masked multiplier over GF(2^2), or GF(2^4) as a tower over GF(2^2).

---
 rtl/dom_gf_pkg.sv | 22 ++
 rtl/dom_gf_mult_pipe_core.sv | 32 +++
 rtl/dom_gf_mult_pipe.sv | 121 ++++++++++++
 tb/tb_dom_gf_mult_pipe.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dom_gf_pkg.sv
// Shared definitions for the DOM-independent masked GF multiplier.
//   gf2_t      : one GF(2^2) element
//   GF_NU      : tower-field constant nu used to fold ah*bh into the low half
//   rnd_width  : number of fresh-mask bits needed per accepted operand
//   pair_index : position of share pair (k,l), k<l, in lexicographic order
package dom_gf_pkg;

  typedef logic [1:0] gf2_t;

  localparam gf2_t GF_NU = 2'b10;

  function automatic int rnd_width(input int shares, input int gf_width);
    return shares * (shares - 1) / 2 * gf_width;
  endfunction

  // Pairs ordered (0,1),(0,2)..(0,S-1),(1,2)...; rows before k hold
  // (S-1)+(S-2)+...+(S-k) entries.
  function automatic int pair_index(input int shares, input int k, input int l);
    return k * shares - (k * (k + 1)) / 2 + (l - k - 1);
  endfunction

endpackage

// File: rtl/dom_gf_mult_pipe_core.sv
// gf_mult_core: combinational unmasked multiplier over GF(2^2) or the tower
// field GF((2^2)^2).
//   a, b : operands (GF_WIDTH bits)
//   p    : product a*b (GF_WIDTH bits)
module gf_mult_core
  import dom_gf_pkg::*;
#(
  parameter int GF_WIDTH = 2
) (
  input  logic [GF_WIDTH-1:0] a,
  input  logic [GF_WIDTH-1:0] b,
  output logic [GF_WIDTH-1:0] p
);

  function automatic gf2_t gf2_mul(input gf2_t u, input gf2_t v);
    return {(u[1] & v[0]) ^ (u[0] & v[1]) ^ (u[1] & v[1]),
            (u[0] & v[0]) ^ (u[1] & v[1])};
  endfunction

  if (GF_WIDTH == 4) begin : g_gf4
    gf2_t hh, hl, lh, ll;
    assign hh = gf2_mul(a[3:2], b[3:2]);
    assign hl = gf2_mul(a[3:2], b[1:0]);
    assign lh = gf2_mul(a[1:0], b[3:2]);
    assign ll = gf2_mul(a[1:0], b[1:0]);
    // High half keeps the cross terms; ah*bh reduces into the low half via nu.
    assign p  = {hh ^ hl ^ lh, gf2_mul(GF_NU, hh) ^ ll};
  end else begin : g_gf2
    assign p = gf2_mul(a, b);
  end

endmodule

// File: rtl/dom_gf_mult_pipe.sv
// dom_gf_mult_pipe: pipelined DOM-independent masked multiplier over GF(2^2)
// or GF((2^2)^2), SHARES Boolean shares, valid/ready handshake on both sides.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (x_sh, y_sh, rnd taken on accept)
//   x_sh, y_sh          : shared operands, share i at [i*GF_WIDTH +: GF_WIDTH]
//   rnd                 : fresh masks, pair (k,l) at pair_index*GF_WIDTH
//   out_valid/out_ready : result handshake
//   z_sh                : shared product, same packing as the operands
// Build option: DOM_MULT_OUTREG_EN adds a third register stage on z_sh.
module dom_gf_mult_pipe
  import dom_gf_pkg::*;
#(
  parameter int SHARES   = 2,
  parameter int GF_WIDTH = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [SHARES*GF_WIDTH-1:0]                x_sh,
  input  logic [SHARES*GF_WIDTH-1:0]                y_sh,
  input  logic [rnd_width(SHARES, GF_WIDTH)-1:0]    rnd,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [SHARES*GF_WIDTH-1:0]                z_sh
);

  localparam int SW = SHARES * GF_WIDTH;
  localparam int NP = SHARES * SHARES;

  logic [GF_WIDTH-1:0] term [NP];
  logic [GF_WIDTH-1:0] p_p1 [NP];
  logic                vld_p1;
  logic                vld_p2;
  logic [SW-1:0]       z_p2;
  logic [SW-1:0]       zsum;
  logic                adv2;
  logic                nxt_ready;
  logic                acc;

  for (genvar i = 0; i < SHARES; i++) begin : g_row
    for (genvar j = 0; j < SHARES; j++) begin : g_col
      logic [GF_WIDTH-1:0] prod;
      gf_mult_core #(.GF_WIDTH(GF_WIDTH)) u_mul (
        .a (x_sh[i*GF_WIDTH +: GF_WIDTH]),
        .b (y_sh[j*GF_WIDTH +: GF_WIDTH]),
        .p (prod)
      );
      if (i == j) begin : g_inner
        assign term[i*SHARES+j] = prod;
      end else begin : g_cross
        // (i,j) and (j,i) share one mask so it cancels in the unmasked sum.
        localparam int IDX = pair_index(SHARES, (i < j) ? i : j, (i < j) ? j : i);
        assign term[i*SHARES+j] = prod ^ rnd[IDX*GF_WIDTH +: GF_WIDTH];
      end
    end
  end

  assign adv2     = !vld_p2 || nxt_ready;
  assign in_ready = !vld_p1 || adv2;
  assign acc      = in_valid && in_ready;

  // ---- stage 1: masked partial products ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      for (int k = 0; k < NP; k++) p_p1[k] <= '0;
    end else begin
      if (in_ready) vld_p1 <= in_valid;
      if (acc) begin
        for (int k = 0; k < NP; k++) p_p1[k] <= term[k];
      end
    end
  end

  always_comb begin
    zsum = '0;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        zsum[i*GF_WIDTH +: GF_WIDTH] = zsum[i*GF_WIDTH +: GF_WIDTH] ^ p_p1[i*SHARES+j];
      end
    end
  end

  // ---- stage 2: per-domain compression of registered terms ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      z_p2   <= '0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) z_p2 <= zsum;
    end
  end

`ifdef DOM_MULT_OUTREG_EN
  logic          vld_p3;
  logic [SW-1:0] z_p3;

  assign nxt_ready = !vld_p3 || out_ready;

  // ---- stage 3: output boundary register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p3 <= 1'b0;
      z_p3   <= '0;
    end else if (nxt_ready) begin
      vld_p3 <= vld_p2;
      if (vld_p2) z_p3 <= z_p2;
    end
  end

  assign out_valid = vld_p3;
  assign z_sh      = z_p3;
`else
  assign nxt_ready = out_ready;
  assign out_valid = vld_p2;
  assign z_sh      = z_p2;
`endif

endmodule

// File: tb/tb_dom_gf_mult_pipe.sv
// Scoreboard bench for dom_gf_mult_pipe: instance a = GF(2^2) with 2 shares,
// instance b = GF((2^2)^2) with 3 shares. Honours DOM_MULT_OUTREG_EN.
module tb_dom_gf_mult_pipe;

`ifdef DOM_MULT_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [3:0]  a_x, a_y, a_z;
  logic [1:0]  a_rnd;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [11:0] b_x, b_y, b_z;
  logic [11:0] b_rnd;

  dom_gf_mult_pipe #(.SHARES(2), .GF_WIDTH(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .x_sh(a_x), .y_sh(a_y), .rnd(a_rnd),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .z_sh(a_z));

  dom_gf_mult_pipe #(.SHARES(3), .GF_WIDTH(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x_sh(b_x), .y_sh(b_y), .rnd(b_rnd),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .z_sh(b_z));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [1:0] m2(input logic [1:0] a, input logic [1:0] b);
    return {(a[1] & b[0]) ^ (a[0] & b[1]) ^ (a[1] & b[1]), (a[0] & b[0]) ^ (a[1] & b[1])};
  endfunction

  function automatic logic [3:0] m4(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] hh;
    hh = m2(a[3:2], b[3:2]);
    return {hh ^ m2(a[3:2], b[1:0]) ^ m2(a[1:0], b[3:2]),
            {hh[0] ^ hh[1], hh[1]} ^ m2(a[1:0], b[1:0])};
  endfunction

  typedef struct packed { logic [3:0]  sh; logic [1:0] plain; } a_exp_t;
  typedef struct packed { logic [11:0] sh; logic [3:0] plain; } b_exp_t;
  a_exp_t qa[$];
  b_exp_t qb[$];

  task automatic drive_a(input logic [3:0] x, input logic [3:0] y, input logic [1:0] r,
                         input logic [1:0] plain);
    a_exp_t e;
    int n;
    e.sh[1:0] = m2(x[1:0], y[1:0]) ^ m2(x[1:0], y[3:2]) ^ r;
    e.sh[3:2] = m2(x[3:2], y[3:2]) ^ m2(x[3:2], y[1:0]) ^ r;
    e.plain   = plain;
    a_x = x; a_y = y; a_rnd = r; a_in_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (a_in_ready) begin
        qa.push_back(e);
        break;
      end
      n++;
      if (n > 200) begin
        fail_now("a_accept");
        break;
      end
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic drive_a_rand(input logic [1:0] xp, input logic [1:0] yp, input logic [1:0] plain);
    logic [1:0] x0, y0;
    x0 = 2'($urandom);
    y0 = 2'($urandom);
    drive_a({xp ^ x0, x0}, {yp ^ y0, y0}, 2'($urandom), plain);
  endtask

  task automatic drive_b_rand(input logic [3:0] xp, input logic [3:0] yp, input logic [3:0] plain);
    b_exp_t e;
    logic [3:0] x0, x1, x2, y0, y1, y2, r0, r1, r2;
    int n;
    x0 = 4'($urandom); x1 = 4'($urandom); x2 = xp ^ x0 ^ x1;
    y0 = 4'($urandom); y1 = 4'($urandom); y2 = yp ^ y0 ^ y1;
    r0 = 4'($urandom); r1 = 4'($urandom); r2 = 4'($urandom);
    e.sh[3:0]  = m4(x0, y0) ^ m4(x0, y1) ^ m4(x0, y2) ^ r0 ^ r1;
    e.sh[7:4]  = m4(x1, y0) ^ m4(x1, y1) ^ m4(x1, y2) ^ r0 ^ r2;
    e.sh[11:8] = m4(x2, y0) ^ m4(x2, y1) ^ m4(x2, y2) ^ r1 ^ r2;
    e.plain    = plain;
    b_x = {x2, x1, x0}; b_y = {y2, y1, y0}; b_rnd = {r2, r1, r0}; b_in_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (b_in_ready) begin
        qb.push_back(e);
        break;
      end
      n++;
      if (n > 200) begin
        fail_now("b_accept");
        break;
      end
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  // Output monitors: a transfer happens at the posedge following a negedge
  // where out_valid & out_ready are both seen.
  a_exp_t     a_e;
  b_exp_t     b_e;
  logic       a_hold_pend = 1'b0;
  logic [3:0] a_held;
  logic [3:0] seen0 = 4'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (a_hold_pend) begin
        chk("a_stall_valid", 32'(a_out_valid), 32'd1);
        chk("a_stall_data", 32'(a_z), 32'(a_held));
      end
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          fail_now("a_unexpected_output");
        end else begin
          a_e = qa.pop_front();
          chk("a_shares", 32'(a_z), 32'(a_e.sh));
          chk("a_plain", 32'(a_z[1:0] ^ a_z[3:2]), 32'(a_e.plain));
          seen0[a_z[1:0]] = 1'b1;
        end
      end
    end
    a_hold_pend = !rst && a_out_valid && !a_out_ready;
    a_held      = a_z;
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        fail_now("b_unexpected_output");
      end else begin
        b_e = qb.pop_front();
        chk("b_shares", 32'(b_z), 32'(b_e.sh));
        chk("b_plain", 32'(b_z[3:0] ^ b_z[7:4] ^ b_z[11:8]), 32'(b_e.plain));
      end
    end
  end

  task automatic t1_latency(input string nm);
    int k;
    // x = 01^11 = 10, y = 10^00 = 10, rnd = 0 -> product 11
    drive_a(4'b1101, 4'b0010, 2'b00, 2'b11);
    k = 1;
    while (!a_out_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk(nm, 32'(k), 32'(LAT));
    @(posedge clk); #1;
  endtask

  logic [3:0] pat = 4'b1001;
  bit         b_done = 1'b0;

  initial begin
    int n;
    rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_x = '0; a_y = '0; a_rnd = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_x = '0; b_y = '0; b_rnd = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("a_rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("a_rst_z", 32'(a_z), 32'd0);
    chk("a_rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("b_rst_out_valid", 32'(b_out_valid), 32'd0);
    chk("b_rst_z", 32'(b_z), 32'd0);

    // basic product and latency
    t1_latency("a_latency");

    // x = y = 11 -> 10 for any masks
    for (int i = 0; i < 1000; i++) drive_a_rand(2'b11, 2'b11, 2'b10);
    repeat (LAT + 2) @(posedge clk);
    #1;

    // fill with the consumer stalled, then reset with results in flight
    a_out_ready = 1'b0;
    for (int i = 0; i < LAT; i++) drive_a_rand(2'(i + 1), 2'b01, 2'(i + 1));
    chk("a_full_in_ready", 32'(a_in_ready), 32'd0);
    chk("a_full_out_valid", 32'(a_out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("a_midrst_out_valid", 32'(a_out_valid), 32'd0);
    chk("a_midrst_z", 32'(a_z), 32'd0);
    chk("a_midrst_in_ready", 32'(a_in_ready), 32'd1);
    qa.delete();
    a_out_ready = 1'b1;
    t1_latency("a_post_rst_latency");

    // back-to-back operands while out_ready runs 1,0,0,1
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          logic [1:0] xp, yp;
          xp = 2'($urandom);
          yp = 2'($urandom);
          drive_a_rand(xp, yp, m2(xp, yp));
        end
      end
      begin
        for (int k = 0; k < 24; k++) begin
          a_out_ready = pat[k % 4];
          @(posedge clk); #1;
        end
        a_out_ready = 1'b1;
      end
    join

    // tower field: hand values, then all pairs with random masks and stalls
    drive_b_rand(4'h4, 4'h4, 4'h6);
    drive_b_rand(4'h2, 4'h2, 4'h3);
    drive_b_rand(4'h1, 4'hB, 4'hB);
    fork
      begin
        for (int x = 0; x < 16; x++) begin
          for (int y = 0; y < 16; y++) drive_b_rand(4'(x), 4'(y), m4(4'(x), 4'(y)));
        end
        b_done = 1'b1;
      end
      begin
        while (!b_done) begin
          b_out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        b_out_ready = 1'b1;
      end
    join

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (qa.size() != 0 || qb.size() != 0) fail_now("drain");
    chk("a_share0_varies", 32'($countones(seen0) > 1), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
